// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard: a per-register countdown of cycles until each pending result can be forwarded,
// a multi-cycle mult/div busy counter, and a saturating count of stalled cycles.
module hazard_scoreboard #(
    parameter int NREG     = 32,
    parameter int AW       = 5,
    parameter int TW       = 3,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int CW       = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          d_valid,
    input  logic [AW-1:0] d_rs,
    input  logic [AW-1:0] d_rt,
    input  logic          d_use_rs,
    input  logic          d_use_rt,
    input  logic [TW-1:0] d_tuse_rs,
    input  logic [TW-1:0] d_tuse_rt,
    input  logic          d_we,
    input  logic [AW-1:0] d_a3,
    input  logic [TW-1:0] d_tnew,
    input  logic          d_md_start,
    input  logic          d_md_div,
    input  logic          d_md_use,
    input  logic          flush,
    output logic          stall,
    output logic          md_busy,
    output logic [CW-1:0] stall_cnt
);

    localparam int MD_MAX = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int MDW    = $clog2(MD_MAX + 1);
    localparam logic [TW-1:0]  T_ONE   = {{(TW-1){1'b0}}, 1'b1};
    localparam logic [MDW-1:0] MD_ONE  = {{(MDW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]  CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]  CNT_MAX = {CW{1'b1}};

    logic [TW-1:0]  pend_q [1:NREG-1];
    logic [TW-1:0]  pend_d [1:NREG-1];
    logic [TW-1:0]  pend_rd [0:(2**AW)-1];
    logic [MDW-1:0] md_cnt_q, md_cnt_d;
    logic           md_busy_q;
    logic [CW-1:0]  stall_cnt_q, stall_cnt_d;
    logic           s_rs, s_rt, s_md, stall_s, issue_s;

    // Full-range read view: $0 and indices beyond NREG read as nothing pending.
    always_comb begin
        for (int i = 0; i < 2**AW; i++) begin
            pend_rd[i] = {TW{1'b0}};
        end
        for (int i = 1; i < NREG; i++) begin
            pend_rd[i] = pend_q[i];
        end
    end

    // Hazard detection against current scoreboard state; flush does not mask it.
    always_comb begin
        s_rs    = d_valid && d_use_rs && (d_rs != {AW{1'b0}}) && (pend_rd[d_rs] > d_tuse_rs);
        s_rt    = d_valid && d_use_rt && (d_rt != {AW{1'b0}}) && (pend_rd[d_rt] > d_tuse_rt);
        s_md    = d_valid && d_md_use && (md_cnt_q != {MDW{1'b0}});
        stall_s = s_rs || s_rt || s_md;
        issue_s = d_valid && !stall_s && !flush;
    end

    // Countdown per register; a newly issuing writer overrides whatever was pending.
    always_comb begin
        for (int i = 1; i < NREG; i++) begin
            if (flush) begin
                pend_d[i] = {TW{1'b0}};
            end else if (issue_s && d_we && (d_a3 == AW'(i))) begin
                pend_d[i] = d_tnew;
            end else if (pend_q[i] != {TW{1'b0}}) begin
                pend_d[i] = pend_q[i] - T_ONE;
            end else begin
                pend_d[i] = {TW{1'b0}};
            end
        end
    end

    // Mult/div busy counter and saturating stall counter next state.
    always_comb begin
        if (flush) begin
            md_cnt_d = {MDW{1'b0}};
        end else if (issue_s && d_md_start) begin
            md_cnt_d = d_md_div ? MDW'(DIV_LAT) : MDW'(MULT_LAT);
        end else if (md_cnt_q != {MDW{1'b0}}) begin
            md_cnt_d = md_cnt_q - MD_ONE;
        end else begin
            md_cnt_d = {MDW{1'b0}};
        end

        if (stall_s && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 1; i < NREG; i++) begin
                pend_q[i] <= {TW{1'b0}};
            end
            md_cnt_q    <= {MDW{1'b0}};
            md_busy_q   <= 1'b0;
            stall_cnt_q <= {CW{1'b0}};
        end else begin
            for (int i = 1; i < NREG; i++) begin
                pend_q[i] <= pend_d[i];
            end
            md_cnt_q    <= md_cnt_d;
            md_busy_q   <= (md_cnt_d != {MDW{1'b0}});
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall     = stall_s;
    assign md_busy   = md_busy_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: load-use, branch, writer override, mult/div latency,
// flush, asynchronous reset and stall-counter saturation.
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        reset2 = 1'b1;
    logic        d_valid, d_use_rs, d_use_rt, d_we, d_md_start, d_md_div, d_md_use, flush;
    logic [4:0]  d_rs, d_rt, d_a3;
    logic [2:0]  d_tuse_rs, d_tuse_rt, d_tnew;
    logic        stall, md_busy, stall2, md_busy2;
    logic [15:0] stall_cnt;
    logic [1:0]  stall_cnt2;
    int          n_tests = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk(clk), .reset(reset), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
        .d_use_rs(d_use_rs), .d_use_rt(d_use_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
        .d_we(d_we), .d_a3(d_a3), .d_tnew(d_tnew), .d_md_start(d_md_start), .d_md_div(d_md_div),
        .d_md_use(d_md_use), .flush(flush), .stall(stall), .md_busy(md_busy), .stall_cnt(stall_cnt)
    );

    hazard_scoreboard #(.CW(2)) dut2 (
        .clk(clk), .reset(reset2), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
        .d_use_rs(d_use_rs), .d_use_rt(d_use_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
        .d_we(d_we), .d_a3(d_a3), .d_tnew(d_tnew), .d_md_start(d_md_start), .d_md_div(d_md_div),
        .d_md_use(d_md_use), .flush(flush), .stall(stall2), .md_busy(md_busy2), .stall_cnt(stall_cnt2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        d_valid = 1'b0; d_rs = 5'd0; d_rt = 5'd0; d_use_rs = 1'b0; d_use_rt = 1'b0;
        d_tuse_rs = 3'd0; d_tuse_rt = 3'd0; d_we = 1'b0; d_a3 = 5'd0; d_tnew = 3'd0;
        d_md_start = 1'b0; d_md_div = 1'b0; d_md_use = 1'b0;
        #1;
    endtask

    task automatic alu(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
        idle();
        d_valid = 1'b1; d_rs = rs; d_use_rs = 1'b1; d_tuse_rs = 3'd1;
        d_rt = rt; d_use_rt = 1'b1; d_tuse_rt = 3'd1; d_we = 1'b1; d_a3 = rd; d_tnew = 3'd1;
        #1;
    endtask

    task automatic lw(input logic [4:0] rt, input logic [4:0] base);
        idle();
        d_valid = 1'b1; d_rs = base; d_use_rs = 1'b1; d_tuse_rs = 3'd1;
        d_we = 1'b1; d_a3 = rt; d_tnew = 3'd2;
        #1;
    endtask

    task automatic sw(input logic [4:0] rt, input logic [4:0] base);
        idle();
        d_valid = 1'b1; d_rs = base; d_use_rs = 1'b1; d_tuse_rs = 3'd1;
        d_rt = rt; d_use_rt = 1'b1; d_tuse_rt = 3'd2;
        #1;
    endtask

    task automatic beq(input logic [4:0] rs, input logic [4:0] rt);
        idle();
        d_valid = 1'b1; d_rs = rs; d_use_rs = 1'b1; d_tuse_rs = 3'd0;
        d_rt = rt; d_use_rt = 1'b1; d_tuse_rt = 3'd0;
        #1;
    endtask

    task automatic md_op(input logic is_div);
        idle();
        d_valid = 1'b1; d_rs = 5'd1; d_use_rs = 1'b1; d_tuse_rs = 3'd1;
        d_rt = 5'd2; d_use_rt = 1'b1; d_tuse_rt = 3'd1;
        d_md_start = 1'b1; d_md_div = is_div; d_md_use = 1'b1;
        #1;
    endtask

    task automatic mflo(input logic [4:0] rd);
        idle();
        d_valid = 1'b1; d_md_use = 1'b1; d_we = 1'b1; d_a3 = rd; d_tnew = 3'd1;
        #1;
    endtask

    // Step while stalled (bounded) and compare the number of stalled cycles.
    task automatic count_stalls(input string tag, input int exp);
        int n = 0;
        while (stall && n < 40) begin
            n++;
            step();
        end
        check(tag, 32'(n), 32'(exp));
    endtask

    task automatic drain(input int cycles);
        idle();
        repeat (cycles) step();
    endtask

    initial begin
        flush = 1'b0;
        idle();
        #12;
        check("rst_md_busy", 32'(md_busy), 32'd0);
        check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        alu(5'd9, 5'd8, 5'd1);
        check("rst_stall_empty", 32'(stall), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        idle();

        // Load-use: one bubble.
        lw(5'd8, 5'd1);
        check("lu_lw_nostall", 32'(stall), 32'd0);
        step();
        alu(5'd9, 5'd8, 5'd1);
        check("lu_stall_t1", 32'(stall), 32'd1);
        step();
        check("lu_stall_t2", 32'(stall), 32'd0);
        step();
        check("lu_stall_cnt", 32'(stall_cnt), 32'd1);
        drain(3);

        // Branch after ALU, after load, and store after load.
        alu(5'd4, 5'd1, 5'd2); step();
        beq(5'd4, 5'd0); count_stalls("br_alu", 1); step(); drain(3);
        lw(5'd4, 5'd1); step();
        beq(5'd4, 5'd0); count_stalls("br_lw", 2); step(); drain(3);
        lw(5'd4, 5'd1); step();
        sw(5'd4, 5'd1); count_stalls("sw_lw", 0); step(); drain(3);

        // Newer writer with larger Tnew overrides the older one.
        alu(5'd5, 5'd1, 5'd2); step();
        lw(5'd5, 5'd1);
        check("ovr_lw_nostall", 32'(stall), 32'd0);
        step();
        beq(5'd5, 5'd0); count_stalls("ovr_beq", 2); step(); drain(3);

        // Mult/div latency.
        md_op(1'b0); step();
        mflo(5'd2);
        check("mult_busy", 32'(md_busy), 32'd1);
        count_stalls("mult_stalls", 5);
        check("mult_busy_end", 32'(md_busy), 32'd0);
        step(); drain(3);
        md_op(1'b1); step();
        mflo(5'd2); count_stalls("div_stalls", 10); step(); drain(3);
        check("md_stall_cnt", 32'(stall_cnt), 32'd21);
        md_op(1'b1); step();
        alu(5'd3, 5'd1, 5'd2);
        check("addu_div_busy", 32'(md_busy), 32'd1);
        check("addu_div_nostall", 32'(stall), 32'd0);
        step(); drain(12);

        // Flush: stall still reported, pending entries cleared, issuing writer dropped.
        lw(5'd8, 5'd1); step();
        beq(5'd8, 5'd0);
        flush = 1'b1; #1;
        check("flush_no_mask", 32'(stall), 32'd1);
        step();
        flush = 1'b0; #1;
        check("flush_cleared", 32'(stall), 32'd0);
        step(); drain(2);
        lw(5'd8, 5'd1);
        flush = 1'b1; step();
        flush = 1'b0;
        alu(5'd9, 5'd8, 5'd1);
        check("flush_no_issue", 32'(stall), 32'd0);
        step(); drain(2);

        // Writes to $0 are never tracked.
        alu(5'd0, 5'd1, 5'd2); step();
        beq(5'd0, 5'd0);
        check("zero_alu", 32'(stall), 32'd0);
        lw(5'd0, 5'd1); step();
        beq(5'd0, 5'd0);
        check("zero_lw", 32'(stall), 32'd0);
        step(); drain(2);
        check("total_stall_cnt", 32'(stall_cnt), 32'd22);

        // Asynchronous reset mid-divide.
        md_op(1'b1); step();
        idle(); repeat (4) step();
        mflo(5'd2);
        check("pre_rst_busy", 32'(md_busy), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_busy", 32'(md_busy), 32'd0);
        check("async_rst_cnt", 32'(stall_cnt), 32'd0);
        check("async_rst_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        reset2 = 1'b0;
        idle();

        // Saturation with a 2-bit counter.
        md_op(1'b0); step();
        mflo(5'd2); count_stalls("sat_stalls", 5);
        check("sat_cnt_cw2", 32'(stall_cnt2), 32'd3);
        check("sat_cnt_cw16", 32'(stall_cnt), 32'd5);
        step(); drain(2);
        check("sat_cnt_hold", 32'(stall_cnt2), 32'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got 1 expected 0");
        $fatal(1);
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the fixed E/M-stage Tuse/Tnew stall unit.
- Replaces per-stage decoders with a per-register countdown scoreboard, loaded when a D-stage instruction issues into E.
- Adds an internal multi-cycle mult/div busy counter with separate latencies, a flush clear and a saturating stall-cycle counter.
- Sits beside the D-stage decoder and drives the F/D freeze and E-bubble insertion.

Parameters:
- NREG, 32, number of architectural GPRs.
- AW, 5, register-index width; NREG <= 2**AW.
- TW, 3, width of Tuse/Tnew fields and scoreboard entries.
- MULT_LAT, 5, busy cycles after a mult/multu issues.
- DIV_LAT, 10, busy cycles after a div/divu issues.
- CW, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- d_valid  in  1  D stage holds a real instruction (not a bubble).
- d_rs  in  AW  source register rs.
- d_rt  in  AW  source register rt.
- d_use_rs  in  1  instruction reads rs.
- d_use_rt  in  1  instruction reads rt.
- d_tuse_rs  in  TW  cycles until rs is needed (0 = in D).
- d_tuse_rt  in  TW  cycles until rt is needed.
- d_we  in  1  instruction writes a GPR.
- d_a3  in  AW  destination register.
- d_tnew  in  TW  cycles from E entry until the result is forwardable (ALU/mf 1, load 2).
- d_md_start  in  1  instruction is mult/multu/div/divu.
- d_md_div  in  1  qualifies d_md_start: 1 = divide.
- d_md_use  in  1  instruction is mult/div/mfhi/mflo/mthi/mtlo.
- flush  in  1  synchronous pipeline clear.
- stall  out  1  freeze F/D, bubble E (combinational).
- md_busy  out  1  mult/div counter nonzero (registered).
- stall_cnt  out  CW  total stalled cycles, saturating.

Behaviour:
- State: pend[1..NREG-1], each TW bits; md_cnt, width able to hold max(MULT_LAT, DIV_LAT); stall_cnt. Register 0 has no storage and reads as 0.
- reset (async): all pend = 0, md_cnt = 0, stall_cnt = 0. Outputs: stall follows inputs with empty state; md_busy = 0; stall_cnt = 0.
- Stall terms (combinational, all qualified by d_valid):
  - s_rs = d_use_rs & d_rs != 0 & pend[d_rs] > d_tuse_rs
  - s_rt = d_use_rt & d_rt != 0 & pend[d_rt] > d_tuse_rt
  - s_md = d_md_use & md_cnt != 0
  - stall = s_rs | s_rt | s_md. Comparisons are unsigned.
- issue = d_valid & ~stall & ~flush.
- Scoreboard update, every edge:
  - Each nonzero pend decrements by 1, saturating at 0. E onward always advances, so countdown never pauses.
  - If issue & d_we & d_a3 != 0: pend[d_a3] <= d_tnew. This overrides the decrement of that entry, so the newest writer always wins, even with a smaller or larger Tnew than the older writer.
- MD counter, every edge:
  - If issue & d_md_start: md_cnt <= d_md_div ? DIV_LAT : MULT_LAT.
  - Else if md_cnt != 0: md_cnt decrements.
  - Net effect: an op issued in cycle t gives md_busy = 1 for cycles t+1 .. t+LAT.
- flush: on the edge, all pend and md_cnt clear to 0 and no issue occurs that cycle. stall_cnt is unaffected. stall is not masked by flush.
- stall_cnt: increments on each edge where stall = 1, saturating at 2**CW-1. Cleared only by reset.
- Latency: stall reflects scoreboard state in the same cycle; a pend update is visible to the next cycle's D instruction.
- Mid-operation reset clears everything immediately, with no dependence on clk.

Test Plan:
- Load-use: lw $8 (tnew 2) issues at t; addu $9,$8,$1 (tuse_rs 1) in D at t+1 -> stall = 1 at t+1 only; issues at t+2; stall_cnt = 1.
- Branch hazards:
  - addu $4 (tnew 1) followed by beq $4 (tuse 0) -> 1 stall cycle.
  - lw $4 followed by beq $4 -> 2 stall cycles.
  - sw $4 (tuse_rt 2) after lw $4 -> 0 stalls.
- Writer override: addu $5 (tnew 1) at t, lw $5 (tnew 2) at t+1, beq $5 at t+2 -> pend[5] = 2 at t+2; stall 2 cycles; issue at t+4.
- MD latency:
  - mult at t, mflo in D at t+1 -> md_busy and stall high for t+1..t+5 (5 cycles); mflo issues at t+6.
  - Same sequence with div -> 10 stall cycles.
  - addu after div -> no stall.
- Flush and reset:
  - flush while lw $8 pending -> next-cycle addu $8 does not stall.
  - reset asserted mid-div (md_cnt = 6) -> md_busy = 0 and stall_cnt = 0 without a clock edge.
- Saturation and $0: with CW = 2, 5 consecutive stall cycles -> stall_cnt holds 3. Writes to $0 never stall a $0 reader.
